// File: rtl/adam_core_pause_pkg.sv
// Shared types for the core pause controller: FSM state encoding and counter sizing.
package adam_core_pause_pkg;

  typedef enum logic [1:0] {
    StPaused = 2'd0,
    StRun    = 2'd1,
    StDrain  = 2'd2
  } core_pause_state_t;

  function automatic int unsigned cnt_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/adam_outstanding_cnt.sv
// Per-port in-flight request counter; saturates at zero and flags responses with nothing pending.
module adam_outstanding_cnt
  import adam_core_pause_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CntW = cnt_width(MAX_OUTSTANDING)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            fire_i,
  input  logic            rsp_i,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            underflow_o
);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d     = count_q;
    underflow_o = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (fire_i && !rsp_i) begin
      count_d = count_q + 1'b1;
    end else if (rsp_i && !fire_i) begin
      if (count_q == '0) begin
        underflow_o = 1'b1;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(MAX_OUTSTANDING));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/adam_core_pause_ctrl.sv
// Turns the upstream pause handshake into a safe core halt: gate requests, drain, then ack.
// Optional drain timeout enabled by defining ADAM_CORE_PAUSE_TIMEOUT_EN.
module adam_core_pause_ctrl
  import adam_core_pause_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned NO_PORTS        = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  pause_req_i,
  output logic                  pause_ack_o,
  input  logic                  tgt_rst_i,
  input  logic [ADDR_WIDTH-1:0] tgt_boot_addr_i,
  output logic                  core_rst_o,
  output logic [ADDR_WIDTH-1:0] core_boot_addr_o,
  input  logic [NO_PORTS-1:0]   core_req_valid_i,
  output logic [NO_PORTS-1:0]   core_req_ready_o,
  output logic [NO_PORTS-1:0]   bus_req_valid_o,
  input  logic [NO_PORTS-1:0]   bus_req_ready_i,
  input  logic [NO_PORTS-1:0]   bus_rsp_valid_i,
  output logic                  err_o
);

  localparam int unsigned CntW = cnt_width(MAX_OUTSTANDING);

  if (MAX_OUTSTANDING < 1) begin : g_bad_max_out
    $error("MAX_OUTSTANDING must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  core_pause_state_t     state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  core_rst_q;
  logic [ADDR_WIDTH-1:0] boot_q, boot_d;
  logic                  err_q, err_d;
  logic                  cnt_clr;
  logic                  tmo_err;

  logic [NO_PORTS-1:0]   fire, full, empty, underflow, drained, block;
  logic [CntW-1:0]       count [NO_PORTS];

  assign block            = {NO_PORTS{state_q != StRun}} | full;
  assign bus_req_valid_o  = core_req_valid_i & ~block;
  assign core_req_ready_o = bus_req_ready_i & ~block;
  assign fire             = bus_req_valid_o & bus_req_ready_i;

  for (genvar p = 0; p < NO_PORTS; p++) begin : g_port
    adam_outstanding_cnt #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_cnt (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clr_i       (cnt_clr),
      .fire_i      (fire[p]),
      .rsp_i       (bus_rsp_valid_i[p]),
      .count_o     (count[p]),
      .full_o      (full[p]),
      .empty_o     (empty[p]),
      .underflow_o (underflow[p])
    );
    // Fires are blocked in DRAIN, so a response on a count of one empties the port this edge.
    assign drained[p] = empty[p] | ((count[p] == CntW'(1)) & bus_rsp_valid_i[p]);
  end

`ifdef ADAM_CORE_PAUSE_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            tmo_hit;

  assign tmo_d   = (state_q == StDrain) ? tmo_q + 1'b1 : '0;
  assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    boot_d  = boot_q;
    cnt_clr = 1'b0;
    tmo_err = 1'b0;
    unique case (state_q)
      StPaused: begin
        if (!pause_req_i) begin
          state_d = StRun;
          ack_d   = 1'b0;
          boot_d  = tgt_boot_addr_i;
        end
      end
      StRun: begin
        if (pause_req_i) state_d = StDrain;
      end
      StDrain: begin
        if (!pause_req_i) begin
          state_d = StRun;
        end else if (&drained) begin
          state_d = StPaused;
          ack_d   = 1'b1;
        end else if (tmo_hit) begin
          state_d = StPaused;
          ack_d   = 1'b1;
          cnt_clr = 1'b1;
          tmo_err = 1'b1;
        end
      end
      default: state_d = StPaused;
    endcase
    err_d = err_q | (|underflow) | tmo_err;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StPaused;
      ack_q      <= 1'b1;
      core_rst_q <= 1'b1;
      boot_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      core_rst_q <= tgt_rst_i;
      boot_q     <= boot_d;
      err_q      <= err_d;
    end
  end

  assign pause_ack_o      = ack_q;
  assign core_rst_o       = core_rst_q;
  assign core_boot_addr_o = boot_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_adam_core_pause_ctrl.sv
// Vector bench for adam_core_pause_ctrl: each record's expectations are queued when driven
// and compared mid-cycle against the DUT.
module tb_adam_core_pause_ctrl;

  localparam logic [31:0] BootA = 32'h8000_0000;
  localparam logic [31:0] BootD = 32'hDEAD_0000;

  typedef struct {
    logic        rst_n;
    logic        req;
    logic        trst;
    logic [31:0] boot;
    logic [1:0]  cv;
    logic [1:0]  br;
    logic [1:0]  rsp;
    logic [1:0]  ebv;
    logic [1:0]  ecr;
    logic        eack;
    logic        ecrst;
    logic [31:0] eboot;
    logic        eerr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pause_req = 1'b1;
  logic        pause_ack;
  logic        tgt_rst = 1'b1;
  logic [31:0] tgt_boot = '0;
  logic        core_rst;
  logic [31:0] core_boot;
  logic [1:0]  core_req_valid = '0;
  logic [1:0]  core_req_ready;
  logic [1:0]  bus_req_valid;
  logic [1:0]  bus_req_ready = '0;
  logic [1:0]  bus_rsp_valid = '0;
  logic        err;

  int checks = 0;
  int errors = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  adam_core_pause_ctrl #(
    .ADDR_WIDTH      (32),
    .NO_PORTS        (2),
    .MAX_OUTSTANDING (4),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .pause_req_i      (pause_req),
    .pause_ack_o      (pause_ack),
    .tgt_rst_i        (tgt_rst),
    .tgt_boot_addr_i  (tgt_boot),
    .core_rst_o       (core_rst),
    .core_boot_addr_o (core_boot),
    .core_req_valid_i (core_req_valid),
    .core_req_ready_o (core_req_ready),
    .bus_req_valid_o  (bus_req_valid),
    .bus_req_ready_i  (bus_req_ready),
    .bus_rsp_valid_i  (bus_rsp_valid),
    .err_o            (err)
  );

  function automatic vec_t mk(input logic r, input logic q, input logic t, input logic [31:0] b,
                              input logic [1:0] cv, input logic [1:0] br, input logic [1:0] rs,
                              input logic [1:0] ebv, input logic [1:0] ecr, input logic eack,
                              input logic ecrst, input logic [31:0] eboot, input logic eerr);
    vec_t v;
    v.rst_n = r;   v.req = q;    v.trst = t;     v.boot = b;
    v.cv    = cv;  v.br  = br;   v.rsp  = rs;
    v.ebv   = ebv; v.ecr = ecr;  v.eack = eack;  v.ecrst = ecrst;
    v.eboot = eboot; v.eerr = eerr;
    return v;
  endfunction

  // Running-state vector: out of reset, bus ready, boot address already latched as BootD.
  function automatic vec_t mh(input logic q, input logic [1:0] cv, input logic [1:0] rs,
                              input logic [1:0] ebv, input logic [1:0] ecr, input logic eack,
                              input logic eerr);
    return mk(1'b1, q, 1'b0, BootD, cv, 2'b11, rs, ebv, ecr, eack, 1'b0, BootD, eerr);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    @(posedge clk);
    #1;
    rst_n          = v.rst_n;
    pause_req      = v.req;
    tgt_rst        = v.trst;
    tgt_boot       = v.boot;
    core_req_valid = v.cv;
    bus_req_ready  = v.br;
    bus_rsp_valid  = v.rsp;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("bus_req_valid", idx, 32'(bus_req_valid), 32'(e.ebv));
    chk("core_req_ready", idx, 32'(core_req_ready), 32'(e.ecr));
    chk("pause_ack", idx, 32'(pause_ack), 32'(e.eack));
    chk("core_rst", idx, 32'(core_rst), 32'(e.ecrst));
    chk("core_boot_addr", idx, core_boot, e.eboot);
    chk("err", idx, 32'(err), 32'(e.eerr));
  endtask

  initial begin
    // Reset, release while paused, tgt_rst follow, first unpause latching BootA.
    tbl.push_back(mk(0, 1, 1, 0,     2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0,     2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0,     2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, BootA, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, BootA, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, BootA, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0));
    // Running traffic; boot input changes but the latched address holds.
    tbl.push_back(mk(1, 0, 0, BootD, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 0, 0, BootA, 0));
    tbl.push_back(mk(1, 0, 0, BootD, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 0, 0, BootA, 0));
    tbl.push_back(mk(1, 0, 0, BootD, 2'b10, 2'b11, 2'b00, 2'b10, 2'b11, 0, 0, BootA, 0));
    // Three data requests in flight, then pause: ack one cycle after the third response.
    tbl.push_back(mk(1, 1, 0, BootD, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 0, 0, BootA, 0));
    tbl.push_back(mk(1, 1, 0, BootD, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, BootA, 0));
    tbl.push_back(mk(1, 1, 0, BootD, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 0, 0, BootA, 0));
    tbl.push_back(mk(1, 1, 0, BootD, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 0, 0, BootA, 0));
    tbl.push_back(mk(1, 1, 0, BootD, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 0, 0, BootA, 0));
    tbl.push_back(mk(1, 1, 0, BootD, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, BootA, 0));
    tbl.push_back(mk(1, 0, 0, BootD, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, BootA, 0));
    tbl.push_back(mk(1, 0, 0, BootD, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 0, 0, BootD, 0));
    // Idle pause: ack two cycles after req rises, then resume.
    tbl.push_back(mk(1, 1, 0, BootD, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 0, 0, BootD, 0));
    tbl.push_back(mk(1, 1, 0, BootD, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, BootD, 0));
    tbl.push_back(mk(1, 1, 0, BootD, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, BootD, 0));
    tbl.push_back(mk(1, 0, 0, BootD, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, BootD, 0));
    tbl.push_back(mk(1, 0, 0, BootD, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 0, 0, BootD, 0));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Fill the data port to four, then one response frees exactly one slot.
    for (int i = 0; i < 4; i++) run_vec(mh(0, 2'b10, 2'b00, 2'b10, 2'b11, 0, 0), 100 + i);
    run_vec(mh(0, 2'b10, 2'b00, 2'b00, 2'b01, 0, 0), 104);
    run_vec(mh(0, 2'b10, 2'b10, 2'b00, 2'b01, 0, 0), 105);
    run_vec(mh(0, 2'b10, 2'b00, 2'b10, 2'b11, 0, 0), 106);
    run_vec(mh(0, 2'b10, 2'b00, 2'b00, 2'b01, 0, 0), 107);

    // Abort: two left outstanding, req drops mid-drain, traffic resumes without an ack.
    run_vec(mh(0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0), 200);
    run_vec(mh(0, 2'b00, 2'b10, 2'b00, 2'b11, 0, 0), 201);
    run_vec(mh(1, 2'b00, 2'b00, 2'b00, 2'b11, 0, 0), 202);
    run_vec(mh(1, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0), 203);
    run_vec(mh(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0), 204);
    run_vec(mh(0, 2'b10, 2'b00, 2'b10, 2'b11, 0, 0), 205);
    for (int i = 0; i < 3; i++) run_vec(mh(0, 2'b00, 2'b10, 2'b00, 2'b11, 0, 0), 206 + i);

    // Spurious response on an idle port: sticky error until reset.
    run_vec(mh(0, 2'b00, 2'b01, 2'b00, 2'b11, 0, 0), 300);
    run_vec(mh(0, 2'b00, 2'b00, 2'b00, 2'b11, 0, 1), 301);
    run_vec(mh(0, 2'b00, 2'b00, 2'b00, 2'b11, 0, 1), 302);
    run_vec(mk(0, 1, 0, BootD, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 0, 0, BootD, 1), 303);
    run_vec(mk(1, 1, 0, BootD, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0), 304);

`ifdef ADAM_CORE_PAUSE_TIMEOUT_EN
    // Stuck response: drain gives up 16 cycles after entry with ack and error.
    run_vec(mk(1, 0, 0, BootD, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0), 400);
    run_vec(mh(0, 2'b01, 2'b00, 2'b01, 2'b11, 0, 0), 401);
    run_vec(mh(1, 2'b00, 2'b00, 2'b00, 2'b11, 0, 0), 402);
    for (int i = 0; i < 16; i++) run_vec(mh(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0), 403 + i);
    run_vec(mh(1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1), 419);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
